control_unit: RTL and testbench

Single-cycle ARM control unit driving the `dataPath` control inputs. It decodes the upper instruction bits (`Instr[31:12]`) and evaluates the condition field against an internal NZCV flag register. It produces `RegSrc`, `RegWrite`, `ImmSrc`, `ALUSrc`, `ALUControl`, `MemtoReg`, `PCSrc` and `MemWrite`. It consumes the datapath's `Negative`/`Zero`/`Carry`/`Overflow` outputs and holds the only architectural state outside the register file and PC.

---
 rtl/arm_pkg.sv | 62 ++++++
 rtl/control_unit_if.sv | 23 ++
 rtl/control_unit_cond_logic.sv | 65 ++++++
 rtl/control_unit.sv | 111 +++++++++++
 tb/tb_control_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared encodings for the single-cycle ARM control path: opcodes, ALU commands,
// ALUControl / ImmSrc / RegSrc codes and condition codes.
package arm_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] REG_SRC_NORMAL = 2'b00;
  localparam logic [1:0] REG_SRC_PC_RN  = 2'b01;
  localparam logic [1:0] REG_SRC_RD_RM  = 2'b10;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } main_dec_t;

  // Only the arithmetic commands produce meaningful carry/overflow.
  function automatic logic is_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/flag inputs and decoded controls.
interface control_unit_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemtoReg;
  logic        PCSrc;
  logic        MemWrite;

  modport master (
    output Instr, ALUFlags,
    input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc, MemWrite
  );

  modport slave (
    input  Instr, ALUFlags,
    output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc, MemWrite
  );
endinterface

// File: rtl/control_unit_cond_logic.sv
// NZCV flag register, condition evaluation and gating of the architectural write enables.
module cond_logic
  import arm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       pcs_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  output logic       pc_src_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);

  logic [3:0] flags_q, flags_d;
  logic [1:0] flag_write;
  logic       cond_ex;
  logic       n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: cond_ex = z_f;
      COND_NE: cond_ex = ~z_f;
      COND_CS: cond_ex = c_f;
      COND_CC: cond_ex = ~c_f;
      COND_MI: cond_ex = n_f;
      COND_PL: cond_ex = ~n_f;
      COND_VS: cond_ex = v_f;
      COND_VC: cond_ex = ~v_f;
      COND_HI: cond_ex = c_f & ~z_f;
      COND_LS: cond_ex = ~c_f | z_f;
      COND_GE: cond_ex = (n_f == v_f);
      COND_LT: cond_ex = (n_f != v_f);
      COND_GT: cond_ex = ~z_f & (n_f == v_f);
      COND_LE: cond_ex = z_f | (n_f != v_f);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
    endcase
  end

  assign flag_write = flag_w_i & {2{cond_ex}};

  always_comb begin
    flags_d = flags_q;
    if (flag_write[1]) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_write[0]) flags_d[1:0] = alu_flags_i[1:0];
  end

  // Async clear also blocks capture on any edge seen while reset is held low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

  assign reg_write_o = reg_w_i & cond_ex & reset;
  assign mem_write_o = mem_w_i & cond_ex & reset;
  assign pc_src_o    = pcs_i   & cond_ex & reset;

endmodule

// File: rtl/control_unit.sv
// Single-cycle ARM control unit: main decoder, ALU decoder and PC logic feeding cond_logic.
module control_unit
  import arm_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  control_unit_if.slave  cu
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       unused_rn;

  main_dec_t  dec;
  logic [1:0] alu_ctrl;
  logic [1:0] flag_w;
  logic       cmd_valid;
  logic       reg_w;
  logic       pcs;
  logic       reg_write, mem_write, pc_src;

  assign cond      = cu.Instr[19:16];
  assign op        = cu.Instr[15:14];
  assign funct     = cu.Instr[13:8];
  assign rd        = cu.Instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^cu.Instr[7:4];

  always_comb begin
    dec = '0;
    case (op)
      OP_DP: begin
        dec.reg_src = REG_SRC_NORMAL;
        dec.imm_src = IMM_8;
        dec.alu_src = funct[5];
        dec.reg_w   = 1'b1;
        dec.alu_op  = 1'b1;
      end
      OP_MEM: begin
        dec.imm_src = IMM_12;
        dec.alu_src = 1'b1;
        if (funct[0]) begin
          dec.reg_src    = REG_SRC_NORMAL;
          dec.mem_to_reg = 1'b1;
          dec.reg_w      = 1'b1;
        end else begin
          dec.reg_src = REG_SRC_RD_RM;
          dec.mem_w   = 1'b1;
        end
      end
      OP_B: begin
        dec.reg_src = REG_SRC_PC_RN;
        dec.imm_src = IMM_24;
        dec.alu_src = 1'b1;
        dec.branch  = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  // Unsupported data-processing commands degrade to a no-op: no write, no flags.
  always_comb begin
    alu_ctrl  = ALU_ADD;
    flag_w    = 2'b00;
    cmd_valid = 1'b1;
    if (dec.alu_op) begin
      case (cmd)
        CMD_ADD: alu_ctrl = ALU_ADD;
        CMD_SUB: alu_ctrl = ALU_SUB;
        CMD_AND: alu_ctrl = ALU_AND;
        CMD_ORR: alu_ctrl = ALU_ORR;
        default: begin
          alu_ctrl  = ALU_ADD;
          cmd_valid = 1'b0;
        end
      endcase
      flag_w[1] = funct[0] & cmd_valid;
      flag_w[0] = funct[0] & is_arith(cmd);
    end
  end

  assign reg_w = dec.reg_w & cmd_valid;
  assign pcs   = dec.branch | (reg_w & (rd == 4'hF));

  cond_logic u_cond_logic (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (cond),
    .alu_flags_i (cu.ALUFlags),
    .flag_w_i    (flag_w),
    .pcs_i       (pcs),
    .reg_w_i     (reg_w),
    .mem_w_i     (dec.mem_w),
    .pc_src_o    (pc_src),
    .reg_write_o (reg_write),
    .mem_write_o (mem_write)
  );

  assign cu.RegSrc     = dec.reg_src;
  assign cu.ImmSrc     = dec.imm_src;
  assign cu.ALUSrc     = dec.alu_src;
  assign cu.MemtoReg   = dec.mem_to_reg;
  assign cu.ALUControl = alu_ctrl;
  assign cu.RegWrite   = reg_write;
  assign cu.MemWrite   = mem_write;
  assign cu.PCSrc      = pc_src;

endmodule

// File: tb/tb_control_unit.sv
// Directed plus randomized check of control_unit against a behavioural ARM decode model.
module tb_control_unit;

  logic clk;
  logic reset;

  control_unit_if cu_if ();

  control_unit dut (
    .clk   (clk),
    .reset (reset),
    .cu    (cu_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Architectural flags as the ISA describes them.
  bit n_m, z_m, c_m, v_m;

  typedef struct packed {
    logic [1:0] reg_src;
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic       mem_to_reg;
    logic       pc_src;
    logic       mem_write;
    logic       wr_nz;
    logic       wr_cv;
  } exp_t;

  exp_t       cur_exp;
  logic [3:0] cur_af;

  function automatic bit cond_pass(input logic [3:0] c);
    case (c)
      4'd0:    return z_m;
      4'd1:    return !z_m;
      4'd2:    return c_m;
      4'd3:    return !c_m;
      4'd4:    return n_m;
      4'd5:    return !n_m;
      4'd6:    return v_m;
      4'd7:    return !v_m;
      4'd8:    return c_m && !z_m;
      4'd9:    return !c_m || z_m;
      4'd10:   return n_m == v_m;
      4'd11:   return n_m != v_m;
      4'd12:   return !z_m && (n_m == v_m);
      4'd13:   return z_m || (n_m != v_m);
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [19:0] ins);
    exp_t e;
    int   op, fn, rd, cmd;
    bit   pass, rw, mw, br, arith, known;
    e     = '0;
    op    = int'(ins[15:14]);
    fn    = int'(ins[13:8]);
    rd    = int'(ins[3:0]);
    cmd   = (fn / 2) % 16;
    pass  = cond_pass(ins[19:16]);
    rw    = 0;
    mw    = 0;
    br    = 0;
    if (op == 0) begin
      known     = (cmd == 4) || (cmd == 2) || (cmd == 0) || (cmd == 12);
      arith     = (cmd == 4) || (cmd == 2);
      e.alu_src = fn[5];
      if (cmd == 2)       e.alu_ctrl = 2'd1;
      else if (cmd == 0)  e.alu_ctrl = 2'd2;
      else if (cmd == 12) e.alu_ctrl = 2'd3;
      rw      = known;
      e.wr_nz = known && fn[0] && pass;
      e.wr_cv = arith && fn[0] && pass;
    end else if (op == 1) begin
      e.imm_src = 2'd1;
      e.alu_src = 1'b1;
      if (fn[0]) begin
        rw           = 1;
        e.mem_to_reg = 1'b1;
      end else begin
        mw        = 1;
        e.reg_src = 2'd2;
      end
    end else if (op == 2) begin
      e.reg_src = 2'd1;
      e.imm_src = 2'd2;
      e.alu_src = 1'b1;
      br        = 1;
    end
    e.reg_write = rw && pass && reset;
    e.mem_write = mw && pass && reset;
    e.pc_src    = (br || (rw && rd == 15)) && pass && reset;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".RegSrc"},     {6'd0, cu_if.RegSrc},     {6'd0, e.reg_src});
    chk({tag, ".RegWrite"},   {7'd0, cu_if.RegWrite},   {7'd0, e.reg_write});
    chk({tag, ".ImmSrc"},     {6'd0, cu_if.ImmSrc},     {6'd0, e.imm_src});
    chk({tag, ".ALUSrc"},     {7'd0, cu_if.ALUSrc},     {7'd0, e.alu_src});
    chk({tag, ".ALUControl"}, {6'd0, cu_if.ALUControl}, {6'd0, e.alu_ctrl});
    chk({tag, ".MemtoReg"},   {7'd0, cu_if.MemtoReg},   {7'd0, e.mem_to_reg});
    chk({tag, ".PCSrc"},      {7'd0, cu_if.PCSrc},      {7'd0, e.pc_src});
    chk({tag, ".MemWrite"},   {7'd0, cu_if.MemWrite},   {7'd0, e.mem_write});
  endtask

  // Present an instruction and check outputs at the following falling edge.
  task automatic apply(input logic [31:0] word, input logic [3:0] af, input string tag);
    cu_if.Instr    = word[31:12];
    cu_if.ALUFlags = af;
    cur_af         = af;
    @(negedge clk);
    cur_exp = model(word[31:12]);
    check_all(tag, cur_exp);
  endtask

  // Clock the instruction through: flags update with the pre-edge condition result.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      if (cur_exp.wr_nz) {n_m, z_m} = cur_af[3:2];
      if (cur_exp.wr_cv) {c_m, v_m} = cur_af[1:0];
    end
    #1;
  endtask

  task automatic clear_model();
    {n_m, z_m, c_m, v_m} = 4'b0000;
  endtask

  logic [31:0] rword;
  logic [3:0]  rcond;
  logic [1:0]  rop;

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_model();
    reset          = 1'b0;
    cu_if.Instr    = 20'hE2802;
    cu_if.ALUFlags = 4'b0000;
    cur_af         = 4'b0000;

    // Reset held: decode visible, enables suppressed
    apply(32'hE2802005, 4'b0000, "reset_hold");
    chk("reset_hold.RegWrite_const", {7'd0, cu_if.RegWrite}, 8'd0);
    tick();
    reset = 1'b1;

    apply(32'hE2802005, 4'b0000, "add_imm");
    chk("add_imm.RegWrite_const",   {7'd0, cu_if.RegWrite},   8'd1);
    chk("add_imm.ALUSrc_const",     {7'd0, cu_if.ALUSrc},     8'd1);
    chk("add_imm.ALUControl_const", {6'd0, cu_if.ALUControl}, 8'd0);
    chk("add_imm.PCSrc_const",      {7'd0, cu_if.PCSrc},      8'd0);
    tick();

    // Failed condition with flags clear
    apply(32'h02802005, 4'b1111, "addeq_fail");
    chk("addeq_fail.RegWrite_const", {7'd0, cu_if.RegWrite}, 8'd0);
    chk("addeq_fail.MemWrite_const", {7'd0, cu_if.MemWrite}, 8'd0);
    chk("addeq_fail.PCSrc_const",    {7'd0, cu_if.PCSrc},    8'd0);
    tick();
    apply(32'hE280F004, 4'b0000, "add_r15");
    chk("add_r15.PCSrc_const",    {7'd0, cu_if.PCSrc},    8'd1);
    chk("add_r15.RegWrite_const", {7'd0, cu_if.RegWrite}, 8'd1);
    tick();

    // SUBS sets Z, then conditional branches
    apply(32'hE0511001, 4'b0100, "subs");
    chk("subs.ALUControl_const", {6'd0, cu_if.ALUControl}, 8'd1);
    tick();
    apply(32'h0A000002, 4'b0000, "beq_taken");
    chk("beq_taken.PCSrc_const",  {7'd0, cu_if.PCSrc},  8'd1);
    chk("beq_taken.ImmSrc_const", {6'd0, cu_if.ImmSrc}, 8'd2);
    chk("beq_taken.RegSrc_const", {6'd0, cu_if.RegSrc}, 8'd1);
    tick();
    apply(32'h1A000002, 4'b0000, "bne_not_taken");
    chk("bne_not_taken.PCSrc_const", {7'd0, cu_if.PCSrc}, 8'd0);
    tick();

    // Load / store
    apply(32'hE5912000, 4'b0000, "ldr");
    chk("ldr.MemtoReg_const", {7'd0, cu_if.MemtoReg}, 8'd1);
    chk("ldr.ImmSrc_const",   {6'd0, cu_if.ImmSrc},   8'd1);
    chk("ldr.RegWrite_const", {7'd0, cu_if.RegWrite}, 8'd1);
    tick();
    apply(32'hE5812000, 4'b0000, "str");
    chk("str.MemWrite_const", {7'd0, cu_if.MemWrite}, 8'd1);
    chk("str.RegWrite_const", {7'd0, cu_if.RegWrite}, 8'd0);
    chk("str.RegSrc_const",   {6'd0, cu_if.RegSrc},   8'd2);
    tick();

    // ADDS to reach flags 0011, then ANDS updates NZ only
    apply(32'hE0911001, 4'b0011, "adds_cv");
    tick();
    apply(32'h0A000002, 4'b0000, "beq_after_adds");
    chk("beq_after_adds.PCSrc_const", {7'd0, cu_if.PCSrc}, 8'd0);
    tick();
    apply(32'hE0111001, 4'b1100, "ands");
    tick();
    apply(32'h4A000000, 4'b0000, "bmi_1111");
    chk("bmi_1111.PCSrc_const", {7'd0, cu_if.PCSrc}, 8'd1);
    tick();
    apply(32'h2A000000, 4'b0000, "bcs_1111");
    chk("bcs_1111.PCSrc_const", {7'd0, cu_if.PCSrc}, 8'd1);
    tick();
    apply(32'h6A000000, 4'b0000, "bvs_1111");
    chk("bvs_1111.PCSrc_const", {7'd0, cu_if.PCSrc}, 8'd1);
    tick();
    apply(32'hE2802005, 4'b0000, "add_nos");
    tick();
    apply(32'h0A000000, 4'b0000, "beq_hold");
    chk("beq_hold.PCSrc_const", {7'd0, cu_if.PCSrc}, 8'd1);
    tick();
    apply(32'h6A000000, 4'b0000, "bvs_hold");
    chk("bvs_hold.PCSrc_const", {7'd0, cu_if.PCSrc}, 8'd1);
    tick();

    // Undefined opcode
    apply(32'hEC00F000, 4'b0000, "undef_op");
    chk("undef_op.RegWrite_const", {7'd0, cu_if.RegWrite}, 8'd0);
    chk("undef_op.MemWrite_const", {7'd0, cu_if.MemWrite}, 8'd0);
    chk("undef_op.PCSrc_const",    {7'd0, cu_if.PCSrc},    8'd0);
    tick();

    // Mid-run reset with Z set
    apply(32'hE0511001, 4'b0100, "subs_z");
    tick();
    cu_if.Instr = 20'h0A000;
    #2;
    chk("pre_reset_beq.PCSrc", {7'd0, cu_if.PCSrc}, 8'd1);
    reset = 1'b0;
    clear_model();
    #1;
    chk("mid_reset.PCSrc", {7'd0, cu_if.PCSrc}, 8'd0);
    check_all("mid_reset", model(cu_if.Instr));
    cu_if.Instr    = 20'hE0111;
    cu_if.ALUFlags = 4'b1111;
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(32'h0A000002, 4'b0000, "beq_after_reset");
    chk("beq_after_reset.PCSrc_const", {7'd0, cu_if.PCSrc}, 8'd0);
    tick();
    apply(32'h4A000002, 4'b0000, "bmi_after_reset");
    tick();

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      rword = $urandom;
      rcond = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rop   = 2'($urandom_range(0, 3));
      rword[31:28] = rcond;
      rword[27:26] = rop;
      if ($urandom_range(0, 1) == 1) rword[24:21] = 4'($urandom_range(0, 1) * 4);
      apply(rword, 4'($urandom_range(0, 15)), "rand");
      if ($urandom_range(0, 29) == 0) begin
        #1;
        reset = 1'b0;
        clear_model();
        #1;
        check_all("rand_reset", model(cu_if.Instr));
        @(posedge clk);
        #1;
        reset = 1'b1;
      end else begin
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
